// File: rtl/amo_rmw_sequencer_if.sv
// Bundle of the request, array, ALU and response signals around amo_rmw_sequencer.
// master = the sequencer's view; slave = the surrounding requester/array/ALU view.
interface amo_rmw_sequencer_if #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned TAG_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_cmd;
  logic [1:0]        req_size;
  logic [63:0]       req_data;
  logic [TAG_W-1:0]  req_tag;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rdata_valid;
  logic [63:0]       rdata;

  logic [7:0]        alu_mask;
  logic [4:0]        alu_cmd;
  logic [63:0]       alu_lhs;
  logic [63:0]       alu_rhs;
  logic [63:0]       alu_out;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic [7:0]        wr_mask;

  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;
  logic              busy;

  modport master (
    input  req_valid, req_addr, req_cmd, req_size, req_data, req_tag,
    input  rd_ready, rdata_valid, rdata, alu_out, wr_ready, resp_ready,
    output req_ready, rd_valid, rd_addr, alu_mask, alu_cmd, alu_lhs, alu_rhs,
    output wr_valid, wr_addr, wr_data, wr_mask,
    output resp_valid, resp_data, resp_tag, resp_err, busy
  );

  modport slave (
    output req_valid, req_addr, req_cmd, req_size, req_data, req_tag,
    output rd_ready, rdata_valid, rdata, alu_out, wr_ready, resp_ready,
    input  req_ready, rd_valid, rd_addr, alu_mask, alu_cmd, alu_lhs, alu_rhs,
    input  wr_valid, wr_addr, wr_data, wr_mask,
    input  resp_valid, resp_data, resp_tag, resp_err, busy
  );
endinterface

// File: rtl/amo_rmw_sequencer.sv
// Single-outstanding AMO read-modify-write sequencer: reads the aligned dword,
// feeds the downstream AMO ALU from registers, writes the result back, returns the pre-op value.
module amo_rmw_sequencer #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned TAG_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  amo_rmw_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_EXEC, S_WRITE, S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic [4:0]        cmd_q, cmd_d;
  logic [1:0]        size_q, size_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [63:0]       rhs_q, rhs_d;
  logic [7:0]        mask_q, mask_d;
  logic [63:0]       lhs_q, lhs_d;
  logic [63:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_valid_q, wr_valid_d;
  logic              resp_valid_q, resp_valid_d;
  logic              busy_q, busy_d;

  logic              req_ready;
  logic              req_err;
  logic [31:0]       lane_word;

  // Gated by reset so nothing is accepted while the block is held in reset.
  assign req_ready = (state_q == S_IDLE) && !reset;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    size_d    = size_q;
    tag_d     = tag_q;
    rhs_d     = rhs_q;
    mask_d    = mask_q;
    lhs_d     = lhs_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    req_err = (bus.req_size < 2'd2)
           || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00))
           || ((bus.req_size == 2'd3) && (bus.req_addr[2:0] != 3'b000));

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready) begin
          addr_d = bus.req_addr[ADDR_W-1:2];
          cmd_d  = bus.req_cmd;
          size_d = bus.req_size;
          tag_d  = bus.req_tag;
          err_d  = req_err;
          if (bus.req_size == 2'd3) begin
            mask_d = 8'hFF;
            rhs_d  = bus.req_data;
          end else begin
            mask_d = bus.req_addr[2] ? 8'hF0 : 8'h0F;
            rhs_d  = {bus.req_data[31:0], bus.req_data[31:0]};
          end
          state_d = req_err ? S_RESP : S_READ;
        end
      end
      S_READ:  if (bus.rd_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.rdata_valid) begin
          lhs_d   = bus.rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wr_data_d = bus.alu_out;
        state_d   = S_WRITE;
      end
      S_WRITE: if (bus.wr_ready) state_d = S_RESP;
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Valids are registered from the next state so none depends combinationally on its ready.
    rd_valid_d   = (state_d == S_READ);
    wr_valid_d   = (state_d == S_WRITE);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cmd_q        <= '0;
      size_q       <= '0;
      tag_q        <= '0;
      rhs_q        <= '0;
      mask_q       <= '0;
      lhs_q        <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      size_q       <= size_d;
      tag_q        <= tag_d;
      rhs_q        <= rhs_d;
      mask_q       <= mask_d;
      lhs_q        <= lhs_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      wr_valid_q   <= wr_valid_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign lane_word = addr_q[2] ? lhs_q[63:32] : lhs_q[31:0];

  assign bus.req_ready  = req_ready;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_addr    = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.alu_mask   = mask_q;
  assign bus.alu_cmd    = cmd_q;
  assign bus.alu_lhs    = lhs_q;
  assign bus.alu_rhs    = rhs_q;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_mask    = mask_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = err_q ? '0
                        : (size_q == 2'd3) ? lhs_q
                        : {{32{lane_word[31]}}, lane_word};
  assign bus.resp_tag   = tag_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/amo_rmw_sequencer.md
# amo_rmw_sequencer

Sequences one atomic memory operation at a time as a read-modify-write around the data array, and drives the AMO ALU that sits directly downstream of it. It accepts an AMO request and reads the aligned 64-bit word. It then presents the byte mask, command and operands to the ALU, writes the merged ALU result back, and returns the pre-op value to the requester. It sits between the AMO request path and the cache data array.

## Interface
- ADDR_W, 40, byte address width
- TAG_W, 8, requester tag width

- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- req_valid / req_ready  in/out  1/1  request handshake
- req_addr  in  ADDR_W  byte address
- req_cmd  in  5  AMO command (codebase M_XA_* encoding), passed to ALU unchanged
- req_size  in  2  log2 bytes; 2 = word, 3 = dword
- req_data  in  64  rhs operand, right-justified
- req_tag  in  TAG_W  returned on response
- rd_valid / rd_ready  out/in  1/1  array read handshake
- rd_addr  out  ADDR_W  {addr[ADDR_W-1:3], 3'b000}
- rdata_valid  in  1  read data return, earliest the cycle after rd fire
- rdata  in  64  read data
- alu_mask  out  8  byte mask to ALU
- alu_cmd  out  5  command to ALU
- alu_lhs / alu_rhs  out  64  operands to ALU
- alu_out  in  64  masked ALU result (unselected bytes = lhs)
- wr_valid / wr_ready  out/in  1/1  array write handshake
- wr_addr  out  ADDR_W  same as rd_addr
- wr_data  out  64  registered alu_out
- wr_mask  out  8  equals alu_mask
- resp_valid / resp_ready  out/in  1/1  response handshake
- resp_data  out  64  pre-op value
- resp_tag  out  TAG_W  latched req_tag
- resp_err  out  1  misaligned or unsupported size
- busy  out  1  state != IDLE

## Operation
- States: IDLE, READ, WAIT, EXEC, WRITE, RESP.
- IDLE:
  - req_ready = 1 (forced 0 while reset is high).
  - On fire, latch addr, cmd, size, tag and data.
  - Error if size < 2, or size 2 with addr[1:0] != 0, or size 3 with addr[2:0] != 0. Error goes to RESP; otherwise go to READ.
- Mask:
  - size 3 → 8'hFF.
  - size 2 → 8'h0F when addr[2] = 0, 8'hF0 when addr[2] = 1.
- rhs:
  - size 3 → req_data.
  - size 2 → {req_data[31:0], req_data[31:0]}.
- READ: rd_valid = 1; rd fire → WAIT.
- WAIT: rdata_valid → latch rdata into lhs register → EXEC. rdata_valid in any other state is ignored.
- EXEC (exactly 1 cycle): latch alu_out into wr_data register → WRITE.
- WRITE: wr_valid = 1; wr fire → RESP.
- RESP: resp_valid = 1; resp fire → IDLE.
- alu_mask, alu_cmd, alu_lhs and alu_rhs are driven from registers, so they are stable from WAIT exit through RESP.
- resp_data:
  - size 3 → lhs.
  - size 2 → lane word (lhs[63:32] when addr[2] = 1, else lhs[31:0]), sign-extended to 64.
  - Error → resp_data = 0, resp_err = 1.
  - resp_err = 0 otherwise.
- No rd or wr is issued for errors.

## Timing
- Reset (async assert, sync deassert by the system):
  - state = IDLE.
  - rd_valid, wr_valid, resp_valid, resp_err and busy = 0.
  - req_ready = 0 while reset is high.
  - All data registers = 0.
- Minimum latency with all readies high and rdata the cycle after rd fire:
  - req fire at cycle 0.
  - rd_valid at cycle 1.
  - rdata at cycle 2.
  - EXEC at cycle 3.
  - wr_valid at cycle 4.
  - resp_valid at cycle 5.
  - req_ready at cycle 6.
- Error path: resp_valid at cycle 1; req_ready again at cycle 2 after resp fire.
- Valid/payload stability:
  - Each valid, once raised, holds with a constant payload until its ready.
  - No valid depends combinationally on its own ready.
- One request is in flight at a time; req_ready = 0 whenever busy.
- Reset mid-operation aborts immediately: all valids drop and the latched state is discarded. A late rdata_valid after reset is ignored.

## Test plan
- amoadd.d: cmd 8, addr 0x1000, size 3, data 5, array 0x10 → rd_addr 0x1000; alu_mask FF; wr_data 0x15, wr_mask FF; resp_data 0x10, resp_err 0; 6 cycles accept-to-accept.
- amomax.w upper lane: cmd 0xD, addr 0x1004, size 2, data 1, array 0x80000000_00000007 → alu_rhs 0x00000001_00000001; wr_data 0x00000001_00000007, wr_mask F0; resp_data 0xFFFFFFFF_80000000.
- amoswap.w lower lane: cmd 4, addr 0x2000, size 2, data 0xAABBCCDD, array 0x11223344_55667788 → wr_data 0x11223344_AABBCCDD, wr_mask 0F; resp_data 0x00000000_55667788.
- Misaligned: addr 0x1002, size 2 → no rd_valid or wr_valid; resp_valid at cycle 1 with resp_err 1 and resp_data 0; tag returned.
- Backpressure: rd_ready, wr_ready and resp_ready each held low 3 cycles → valids and payloads held constant; result identical to the no-stall case; req_ready stays 0 throughout.
- Reset asserted in WAIT, then rdata_valid pulsed after deassert → all outputs at reset values, no wr_valid, next request processed normally.
